// File: rtl/pipelined_mult_array_if.sv
// Operand/result channel of the pipelined multiplier: valid/ready on both sides,
// with a sideband tag that travels with each operation.
interface pipelined_mult_array_if #(
    parameter int WIDTH = 11,
    parameter int TAG_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_signed;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_prod;
    logic [TAG_W-1:0]     out_tag;

    modport master (
        output in_valid, in_signed, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_prod, out_tag
    );

    modport slave (
        input  in_valid, in_signed, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_prod, out_tag
    );
endinterface

// File: rtl/pipelined_mult_array.sv
// Exact WIDTH x WIDTH multiplier (unsigned or Baugh-Wooley signed per op): carry-save
// tree plus final adder over LATENCY stages, with a global stall on output backpressure.
module pipelined_mult_array #(
    parameter int WIDTH   = 11,
    parameter int LATENCY = 3,
    parameter int TAG_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    pipelined_mult_array_if.slave   bus
);
    localparam int P   = 2 * WIDTH;
    localparam int NPP = WIDTH + 1;

    function automatic int next_rows(input int r);
        return (r / 3) * 2 + (r % 3);
    endfunction

    function automatic int rows_at(input int lvl);
        int r;
        r = NPP;
        for (int k = 0; k < lvl; k++) r = next_rows(r);
        return r;
    endfunction

    function automatic int count_levels(input int r0);
        int r;
        int n;
        r = r0;
        n = 0;
        while (r > 2) begin
            r = next_rows(r);
            n++;
        end
        return n;
    endfunction

    localparam int NLEV = count_levels(NPP);
    // LATENCY=2 registers only after the full tree; otherwise the tree is cut at mid-depth.
    localparam int CUT  = (LATENCY == 2) ? NLEV : NLEV / 2;

    if (WIDTH < 4 || WIDTH > 32 || LATENCY < 2 || LATENCY > 4) begin : g_bad_param
        $error("pipelined_mult_array: WIDTH must be 4..32 and LATENCY 2..4");
    end

    genvar gl, gi;

    logic adv;
    assign adv          = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = adv;

    // ---------------- valid / tag pipeline ----------------
    logic [LATENCY:1] v_reg;
    logic [TAG_W-1:0] tag_reg [1:LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_reg <= '0;
            for (int k = 1; k <= LATENCY; k++) tag_reg[k] <= '0;
        end else if (adv) begin
            v_reg      <= {v_reg[LATENCY-1:1], bus.in_valid};
            tag_reg[1] <= bus.in_tag;
            for (int k = 2; k <= LATENCY; k++) tag_reg[k] <= tag_reg[k-1];
        end
    end

    // ---------------- partial products ----------------
    logic [P-1:0] node [0:NLEV][0:NPP-1];
    logic [P-1:0] tap  [0:NLEV][0:NPP-1];

    for (gi = 0; gi < WIDTH; gi++) begin : g_pp
        logic [WIDTH-1:0] pp_row;
        always_comb begin
            pp_row = '0;
            // Signed mode complements the cross terms touching exactly one operand MSB.
            for (int i = 0; i < WIDTH; i++)
                pp_row[i] = (bus.in_a[i] & bus.in_b[gi]) ^
                            (bus.in_signed & ((i == WIDTH - 1) != (gi == WIDTH - 1)));
        end
        assign node[0][gi] = {{WIDTH{1'b0}}, pp_row} << gi;
    end

    // Baugh-Wooley correction: +2^WIDTH + 2^(2*WIDTH-1), modulo 2^(2*WIDTH).
    assign node[0][WIDTH] = bus.in_signed ? ((P'(1) << WIDTH) | (P'(1) << (P - 1))) : '0;

    // ---------------- carry-save reduction tree ----------------
    for (gl = 0; gl < NLEV; gl++) begin : g_lvl
        localparam int R   = rows_at(gl);
        localparam int G   = R / 3;
        localparam int REM = R % 3;
        localparam int RN  = rows_at(gl + 1);

        for (gi = 0; gi < G; gi++) begin : g_csa
            logic [P-1:0] x, y, z;
            assign x = tap[gl][3*gi];
            assign y = tap[gl][3*gi+1];
            assign z = tap[gl][3*gi+2];
            assign node[gl+1][2*gi]   = x ^ y ^ z;
            assign node[gl+1][2*gi+1] = ((x & y) | (x & z) | (y & z)) << 1;
        end
        for (gi = 0; gi < REM; gi++) begin : g_pass
            assign node[gl+1][2*G+gi] = tap[gl][3*G+gi];
        end
        for (gi = RN; gi < NPP; gi++) begin : g_zero
            assign node[gl+1][gi] = '0;
        end
    end

    logic [P-1:0] mid_reg [0:NPP-1];

    if (LATENCY >= 3) begin : g_mid
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < NPP; k++) mid_reg[k] <= '0;
            end else if (adv) begin
                for (int k = 0; k < NPP; k++) mid_reg[k] <= node[CUT][k];
            end
        end
    end else begin : g_nomid
        always_comb begin
            for (int k = 0; k < NPP; k++) mid_reg[k] = '0;
        end
    end

    for (gl = 0; gl <= NLEV; gl++) begin : g_tap
        for (gi = 0; gi < NPP; gi++) begin : g_row
            if (gl == CUT && LATENCY >= 3) begin : g_reg
                assign tap[gl][gi] = mid_reg[gi];
            end else begin : g_wire
                assign tap[gl][gi] = node[gl][gi];
            end
        end
    end

    // ---------------- two-vector register and final adder ----------------
    logic [P-1:0] s_reg, c_reg;
    logic [P-1:0] prod_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_reg <= '0;
            c_reg <= '0;
        end else if (adv) begin
            s_reg <= tap[NLEV][0];
            c_reg <= tap[NLEV][1];
        end
    end

    if (LATENCY == 4) begin : g_split
        logic [WIDTH:0]   lo_sum;
        logic [WIDTH-1:0] lo_reg, s_hi_reg, c_hi_reg;
        logic             cy_reg;

        assign lo_sum = {1'b0, s_reg[WIDTH-1:0]} + {1'b0, c_reg[WIDTH-1:0]};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lo_reg   <= '0;
                cy_reg   <= 1'b0;
                s_hi_reg <= '0;
                c_hi_reg <= '0;
                prod_reg <= '0;
            end else if (adv) begin
                lo_reg   <= lo_sum[WIDTH-1:0];
                cy_reg   <= lo_sum[WIDTH];
                s_hi_reg <= s_reg[P-1:WIDTH];
                c_hi_reg <= c_reg[P-1:WIDTH];
                prod_reg <= {s_hi_reg + c_hi_reg + {{(WIDTH-1){1'b0}}, cy_reg}, lo_reg};
            end
        end
    end else begin : g_full
        always_ff @(posedge clk or posedge rst) begin
            if (rst)      prod_reg <= '0;
            else if (adv) prod_reg <= s_reg + c_reg;
        end
    end

    assign bus.out_valid = v_reg[LATENCY];
    assign bus.out_prod  = prod_reg;
    assign bus.out_tag   = tag_reg[LATENCY];
endmodule
